// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: one op per handshake, sub-word load/store steering,
// bus timeout, one-cycle result pulse toward MEM/WB.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an op
// BUSY  | mem_req held, waiting for mem_ready or timeout
// RESP  | out_valid pulse, op results presented
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  control_mem_in,
  input  logic [1:0]  control_wb_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  write_reg_in,
  mem_access_stage_if.master bus,
  output logic        out_valid,
  output logic [1:0]  control_wb_out,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic [1:0]  wb_q, wb_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        is_load_in, is_store_in, is_byte_in, is_half_in, misalign_in;
  logic [1:0]  off_in;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // memread wins when both control bits are set; unknown funct3 falls to word size
  assign off_in      = alu_result_in[1:0];
  assign is_load_in  = control_mem_in[1];
  assign is_store_in = control_mem_in[0] & ~control_mem_in[1];
  assign is_byte_in  = (funct3_in[1:0] == 2'b00);
  assign is_half_in  = (funct3_in[1:0] == 2'b01);
  assign misalign_in = (is_load_in | is_store_in) &
                       (is_half_in ? off_in[0] : (!is_byte_in && off_in != 2'b00));

  always_comb begin
    wstrb_in = 4'h0;
    wdata_in = write_data_in;
    if (is_store_in) begin
      if (is_byte_in) begin
        wstrb_in = 4'b0001 << off_in;
        wdata_in = {4{write_data_in[7:0]}};
      end else if (is_half_in) begin
        wstrb_in = 4'b0011 << off_in;
        wdata_in = {2{write_data_in[15:0]}};
      end else begin
        wstrb_in = 4'hF;
      end
    end
  end

  always_comb begin
    byte_sel = bus.mem_rdata[{alu_q[1:0], 3'b000} +: 8];
    half_sel = alu_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      load_ext = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
    end else if (funct3_q[1:0] == 2'b01) begin
      load_ext = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    wb_d        = wb_q;
    mis_d       = mis_q;
    berr_d      = berr_q;
    read_data_d = read_data_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_d       = alu_result_in;
          rd_d        = write_reg_in;
          funct3_d    = funct3_in;
          is_load_d   = is_load_in;
          read_data_d = 32'h0;
          berr_d      = 1'b0;
          mis_d       = misalign_in;
          wb_d        = misalign_in ? 2'b00 : control_wb_in;
          if ((is_load_in | is_store_in) && !misalign_in) begin
            req_d   = 1'b1;
            we_d    = is_store_in;
            addr_d  = {alu_result_in[31:2], 2'b00};
            wdata_d = wdata_in;
            wstrb_d = wstrb_in;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (is_load_q) read_data_d = load_ext;
          state_d = RESP;
        end else if (cnt_q == '0) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
          wb_d    = 2'b00;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= 3'b000;
      is_load_q   <= 1'b0;
      wb_q        <= 2'b00;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      read_data_q <= 32'h0;
      alu_q       <= 32'h0;
      rd_q        <= 5'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      wb_q        <= wb_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == RESP);
  assign control_wb_out = out_valid ? wb_q : 2'b00;
  assign misalign_err   = out_valid & mis_q;
  assign bus_err        = out_valid & berr_q;
  assign read_data      = read_data_q;
  assign alu_result_out = alu_q;
  assign write_reg_out  = rd_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule
